// File: rtl/mem_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump_pkg
// Description : Shared state encoding and constants for the mem_dump engine.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_dump_pkg;

    localparam int c_WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        READ    = 3'd1,
        CAPTURE = 3'd2,
        HOLD    = 3'd3,
        FINISH  = 3'd4,
        CSUM    = 3'd5
    } mem_dump_state_t;

endpackage : mem_dump_pkg
`default_nettype wire

// File: rtl/mem_dump.sv
`default_nettype none
// ============================================================================
// Module      : mem_dump
// Description : Walks a word-aligned memory range through a synchronous read
//               port and streams (address, data) beats on valid/ready.
//               Define MEM_DUMP_CHECKSUM_EN to append a running-sum beat.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_dump
    import mem_dump_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int COUNT_WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic [COUNT_WIDTH-1:0] word_count,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_rd_en,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [WIDTH-1:0]       mem_rd_data,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [ADDR_WIDTH-1:0]  dump_addr,
    output logic [WIDTH-1:0]       dump_data,
    output logic                   dump_last
);

    mem_dump_state_t        r_state;
    mem_dump_state_t        w_next_state;
    logic [ADDR_WIDTH-1:0]  r_cur_addr;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic                   r_dump_valid;
    logic [ADDR_WIDTH-1:0]  r_dump_addr;
    logic [WIDTH-1:0]       r_dump_data;
    logic                   r_dump_last;
    logic                   w_fire;
    logic                   w_last_word;
    logic                   w_unused_base;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0]       r_sum;
`endif

    assign w_fire        = r_dump_valid & dump_ready;
    assign w_last_word   = (r_remaining == COUNT_WIDTH'(1));
    // Byte-offset bits are ignored; the range is always word aligned.
    assign w_unused_base = ^base_addr[1:0];

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == FINISH);
    assign mem_rd_en   = (r_state == READ);
    assign mem_rd_addr = r_cur_addr;
    assign dump_valid  = r_dump_valid;
    assign dump_addr   = r_dump_addr;
    assign dump_data   = r_dump_data;
    assign dump_last   = r_dump_last;

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (word_count != '0) w_next_state = READ;
`ifdef MEM_DUMP_CHECKSUM_EN
                    else                  w_next_state = CSUM;
`else
                    else                  w_next_state = FINISH;
`endif
                end
            end
            READ:    w_next_state = CAPTURE;
            CAPTURE: w_next_state = HOLD;
            HOLD: begin
                if (w_fire) begin
`ifdef MEM_DUMP_CHECKSUM_EN
                    w_next_state = w_last_word ? CSUM : READ;
`else
                    w_next_state = w_last_word ? FINISH : READ;
`endif
                end
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM:    if (w_fire) w_next_state = FINISH;
`endif
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cur_addr   <= '0;
            r_remaining  <= '0;
            r_dump_valid <= 1'b0;
            r_dump_addr  <= '0;
            r_dump_data  <= '0;
            r_dump_last  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            r_sum        <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cur_addr  <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_remaining <= word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
                        r_sum       <= '0;
                        // An empty dump still reports a (zero) checksum beat.
                        if (word_count == '0) begin
                            r_dump_valid <= 1'b1;
                            r_dump_addr  <= '0;
                            r_dump_data  <= '0;
                            r_dump_last  <= 1'b1;
                        end
`endif
                    end
                end
                CAPTURE: begin
                    r_dump_valid <= 1'b1;
                    r_dump_addr  <= r_cur_addr;
                    r_dump_data  <= mem_rd_data;
`ifdef MEM_DUMP_CHECKSUM_EN
                    r_sum        <= r_sum + mem_rd_data;
                    r_dump_last  <= 1'b0;
`else
                    r_dump_last  <= w_last_word;
`endif
                end
                HOLD: begin
                    if (w_fire) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                        r_remaining  <= r_remaining - COUNT_WIDTH'(1);
                        r_cur_addr   <= r_cur_addr + ADDR_WIDTH'(c_WORD_BYTES);
`ifdef MEM_DUMP_CHECKSUM_EN
                        // Sum already includes this word, added at capture.
                        if (w_last_word) begin
                            r_dump_valid <= 1'b1;
                            r_dump_addr  <= '0;
                            r_dump_data  <= r_sum;
                            r_dump_last  <= 1'b1;
                        end
`endif
                    end
                end
`ifdef MEM_DUMP_CHECKSUM_EN
                CSUM: begin
                    if (w_fire) begin
                        r_dump_valid <= 1'b0;
                        r_dump_last  <= 1'b0;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule : mem_dump
`default_nettype wire

// File: tb/tb_mem_dump.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_dump
// Description : Directed self-checking bench for mem_dump with a synchronous
//               memory model; honours MEM_DUMP_CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_dump;

    localparam int WIDTH       = 32;
    localparam int ADDR_WIDTH  = 11;
    localparam int COUNT_WIDTH = 9;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   start = 1'b0;
    logic [ADDR_WIDTH-1:0]  base_addr = '0;
    logic [COUNT_WIDTH-1:0] word_count = '0;
    logic                   busy;
    logic                   done;
    logic                   mem_rd_en;
    logic [ADDR_WIDTH-1:0]  mem_rd_addr;
    logic [WIDTH-1:0]       mem_rd_data = '0;
    logic                   dump_valid;
    logic                   dump_ready = 1'b0;
    logic [ADDR_WIDTH-1:0]  dump_addr;
    logic [WIDTH-1:0]       dump_data;
    logic                   dump_last;

    logic [WIDTH-1:0] mem [0:511];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] q_addr [$];
    logic [31:0] q_data [$];
    logic        q_last [$];
    logic [31:0] q_rd   [$];
    int first_valid, done_cyc, fire_cyc, done_n;

    mem_dump #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .COUNT_WIDTH(COUNT_WIDTH)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_last  (dump_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr[10:2]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Issue one dump and record reads, beats and done timing (cycle 1 = first cycle after start edge).
    task automatic run_dump(input logic [10:0] base, input logic [8:0] cnt, input int stall);
        int cyc;
        int wait_n;
        bit in_beat;
        bit finished;
        logic [10:0] ha;
        logic [31:0] hd;
        q_addr.delete(); q_data.delete(); q_last.delete(); q_rd.delete();
        first_valid = -1; done_cyc = -1; fire_cyc = -1; done_n = 0;
        wait_n = 0; in_beat = 0; finished = 0; cyc = 0; ha = '0; hd = '0;
        @(negedge clk);
        base_addr  = base;
        word_count = cnt;
        start      = 1'b1;
        dump_ready = (stall == 0);
        while (!finished && cyc < 300) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (mem_rd_en) q_rd.push_back(32'(mem_rd_addr));
            if (done) begin
                done_n++;
                done_cyc = cyc;
                finished = 1;
            end
            if (dump_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (!in_beat) begin
                    in_beat = 1; ha = dump_addr; hd = dump_data; wait_n = 0;
                end else begin
                    check("stall_addr", 32'(dump_addr), 32'(ha));
                    check("stall_data", dump_data, hd);
                end
                if (wait_n >= stall) begin
                    dump_ready = 1'b1;
                    q_addr.push_back(32'(dump_addr));
                    q_data.push_back(dump_data);
                    q_last.push_back(dump_last);
                    fire_cyc = cyc;
                    in_beat  = 0;
                end else begin
                    dump_ready = 1'b0;
                    wait_n++;
                end
            end else begin
                dump_ready = (stall == 0);
            end
        end
        if (!finished) check("timeout_done", 32'd0, 32'd1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_single_pulse", 32'(done), 32'd0);
        dump_ready = 1'b0;
    endtask

    task automatic verify_basic(input string p);
        logic [31:0] ea [4];
        logic [31:0] ed [4];
        logic        el [4];
        int nb;
        ea = '{32'h0, 32'h4, 32'h8, 32'h0};
        ed = '{32'h02402783, 32'h02802803, 32'h010788B3, 32'h05C7D839};
`ifdef MEM_DUMP_CHECKSUM_EN
        nb = 4;
        el = '{1'b0, 1'b0, 1'b0, 1'b1};
`else
        nb = 3;
        el = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
        check({p, "_nbeats"}, 32'(q_addr.size()), 32'(nb));
        for (int i = 0; i < nb; i++) begin
            if (i < q_addr.size()) begin
                check($sformatf("%s_addr%0d", p, i), q_addr[i], ea[i]);
                check($sformatf("%s_data%0d", p, i), q_data[i], ed[i]);
                check($sformatf("%s_last%0d", p, i), 32'(q_last[i]), 32'(el[i]));
            end
        end
        check({p, "_first_valid"}, 32'(first_valid), 32'd3);
        check({p, "_done_count"}, 32'(done_n), 32'd1);
        check({p, "_done_latency"}, 32'(done_cyc), 32'(fire_cyc + 1));
        check({p, "_nreads"}, 32'(q_rd.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < q_rd.size()) check($sformatf("%s_rd%0d", p, i), q_rd[i], 32'(4 * i));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=0x%08h exp=0x%08h", 32'd0, 32'd1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int dn;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[0]   = 32'h02402783;
        mem[1]   = 32'h02802803;
        mem[2]   = 32'h010788B3;
        mem[511] = 32'hDEADBEEF;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_rd_addr", 32'(mem_rd_addr), 32'd0);
        check("rst_valid", 32'(dump_valid), 32'd0);
        check("rst_last", 32'(dump_last), 32'd0);
        check("rst_addr", 32'(dump_addr), 32'd0);
        check("rst_data", dump_data, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_dump(11'h000, 9'd3, 0);
        verify_basic("basic");

        run_dump(11'h000, 9'd3, 5);
        verify_basic("stall");

        run_dump(11'h000, 9'd0, 0);
        check("zero_nreads", 32'(q_rd.size()), 32'd0);
        check("zero_done_count", 32'(done_n), 32'd1);
`ifdef MEM_DUMP_CHECKSUM_EN
        check("zero_nbeats", 32'(q_addr.size()), 32'd1);
        if (q_addr.size() > 0) begin
            check("zero_csum_addr", q_addr[0], 32'd0);
            check("zero_csum_data", q_data[0], 32'd0);
            check("zero_csum_last", 32'(q_last[0]), 32'd1);
        end
`else
        check("zero_nbeats", 32'(q_addr.size()), 32'd0);
        check("zero_done_cyc", 32'(done_cyc), 32'd1);
`endif

        run_dump(11'h7FD, 9'd2, 0);
        check("wrap_nreads", 32'(q_rd.size()), 32'd2);
        if (q_rd.size() == 2) begin
            check("wrap_rd0", q_rd[0], 32'h7FC);
            check("wrap_rd1", q_rd[1], 32'h000);
        end
        if (q_addr.size() >= 2) begin
            check("wrap_addr0", q_addr[0], 32'h7FC);
            check("wrap_data0", q_data[0], 32'hDEADBEEF);
            check("wrap_addr1", q_addr[1], 32'h000);
            check("wrap_data1", q_data[1], 32'h02402783);
`ifndef MEM_DUMP_CHECKSUM_EN
            check("wrap_last1", 32'(q_last[1]), 32'd1);
`endif
        end else begin
            check("wrap_nbeats", 32'(q_addr.size()), 32'd2);
        end

        // Abort while the second beat is held with ready low.
        @(negedge clk);
        base_addr = '0; word_count = 9'd3; start = 1'b1; dump_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        start = 1'b0;
        while (!(dump_valid && dump_addr == 11'h004) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        dump_ready = 1'b0;
        check("abort_reach_hold", 32'(cyc < 50), 32'd1);
        @(negedge clk);
        check("abort_holding", 32'(dump_valid), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_data", dump_data, 32'd0);
        rst = 1'b1;
        dn = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("abort_quiet", 32'(dn), 32'd0);

        run_dump(11'h000, 9'd3, 0);
        verify_basic("rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mem_dump
`default_nettype wire
